// File: rtl/des_pkg.sv
// Shared DES key-schedule definitions: widths, shift schedule, PC2 selection
// and the key-schedule state encoding.
package des_pkg;

    localparam int KEY_W  = 64;
    localparam int CD_W   = 56;
    localparam int HALF_W = 28;
    localparam int SK_W   = 48;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Per-round rotate amounts; entry 0 is round 1.
    localparam int SHIFT_TAB [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    // DES bit numbers (1 = MSB of the 56-bit C||D) feeding subkey bits 1..48.
    localparam int PC2_TAB [SK_W] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    function automatic logic shift_is_two(input logic [3:0] idx);
        return SHIFT_TAB[idx] == 2;
    endfunction

endpackage

// File: rtl/key_schedule_iter_if.sv
// Subkey stream from the key schedule to the round engine (valid/ready).
interface key_schedule_iter_if;

    logic [des_pkg::SK_W-1:0] sk_out;
    logic [3:0]               sk_index;
    logic                     sk_valid;
    logic                     sk_ready;

    modport master (
        output sk_out,
        output sk_index,
        output sk_valid,
        input  sk_ready
    );

    modport slave (
        input  sk_out,
        input  sk_index,
        input  sk_valid,
        output sk_ready
    );

endinterface

// File: rtl/pc1.sv
// DES Permuted Choice 1: 64-bit key to 56-bit C||D, parity bits dropped.
module pc1 (
    input  logic [63:0] key_in,
    output logic [55:0] cd_out
);

    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    for (genvar i = 0; i < 56; i++) begin : g_sel
        assign cd_out[55-i] = key_in[64-PC1_TAB[i]];
    end

    // Parity bits (DES bits 8,16,..,64) take no part in the schedule.
    logic unused_parity;
    assign unused_parity = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                             key_in[24], key_in[16], key_in[8],  key_in[0]};

endmodule

// File: rtl/pc2.sv
// DES Permuted Choice 2: 56-bit C||D to 48-bit round subkey.
module pc2
    import des_pkg::*;
(
    input  logic [CD_W-1:0] cd_in,
    output logic [SK_W-1:0] sk_out
);

    for (genvar i = 0; i < SK_W; i++) begin : g_sel
        assign sk_out[SK_W-1-i] = cd_in[CD_W-PC2_TAB[i]];
    end

endmodule

// File: rtl/key_schedule_iter.sv
// Iterative DES key schedule: emits the 16 round subkeys, one per handshake,
// in encrypt (K1..K16) or decrypt (K16..K1) order.
module key_schedule_iter
    import des_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [KEY_W-1:0]      key_in,
    input  logic                  decrypt,
    output logic                  busy,
    output logic                  done,
    key_schedule_iter_if.master   sk_if
);

    function automatic logic [HALF_W-1:0] rotl(input logic [HALF_W-1:0] x, input logic two);
        return two ? {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]} : {x[HALF_W-2:0], x[HALF_W-1]};
    endfunction

    function automatic logic [HALF_W-1:0] rotr(input logic [HALF_W-1:0] x, input logic two);
        return two ? {x[1:0], x[HALF_W-1:2]} : {x[0], x[HALF_W-1:1]};
    endfunction

    state_e            state_q, state_d;
    logic [3:0]        r_q, r_d;
    logic              dir_q, dir_d;
    logic [HALF_W-1:0] c_q, c_d;
    logic [HALF_W-1:0] d_q, d_d;
    logic              done_q, done_d;

    logic [CD_W-1:0]   pc1_cd;
    logic              handshake;
    logic              enc_two;
    logic              dec_two;

    pc1 u_pc1 (
        .key_in (key_in),
        .cd_out (pc1_cd)
    );

    pc2 u_pc2 (
        .cd_in  ({c_q, d_q}),
        .sk_out (sk_if.sk_out)
    );

    assign handshake = (state_q == RUN) && sk_if.sk_ready;
    assign enc_two   = shift_is_two(r_q + 4'd1);
    assign dec_two   = shift_is_two(4'd15 - r_q);

    // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        dir_d   = dir_q;
        c_d     = c_q;
        d_d     = d_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    r_d     = 4'd0;
                    dir_d   = decrypt;
                    // Decrypt starts from C0,D0: K16 sits a full 28-bit rotation away.
                    if (decrypt) begin
                        c_d = pc1_cd[CD_W-1:HALF_W];
                        d_d = pc1_cd[HALF_W-1:0];
                    end else begin
                        c_d = rotl(pc1_cd[CD_W-1:HALF_W], shift_is_two(4'd0));
                        d_d = rotl(pc1_cd[HALF_W-1:0], shift_is_two(4'd0));
                    end
                end
            end
            RUN: begin
                if (handshake) begin
                    if (r_q == 4'd15) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        r_d = r_q + 4'd1;
                        if (dir_q) begin
                            c_d = rotr(c_q, dec_two);
                            d_d = rotr(d_q, dec_two);
                        end else begin
                            c_d = rotl(c_q, enc_two);
                            d_d = rotl(d_q, enc_two);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            r_q     <= 4'd0;
            dir_q   <= 1'b0;
            c_q     <= '0;
            d_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            dir_q   <= dir_d;
            c_q     <= c_d;
            d_q     <= d_d;
            done_q  <= done_d;
        end
    end

    assign sk_if.sk_valid = (state_q == RUN);
    assign sk_if.sk_index = dir_q ? (4'd15 - r_q) : r_q;
    assign busy           = (state_q == RUN);
    assign done           = done_q;

endmodule

// File: tb/tb_key_schedule_iter.sv
// Self-checking bench for key_schedule_iter against a direct DES key-schedule model.
module tb_key_schedule_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] key_in;
    logic        decrypt;
    logic        busy;
    logic        done;

    key_schedule_iter_if sk_if ();

    key_schedule_iter dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .key_in  (key_in),
        .decrypt (decrypt),
        .busy    (busy),
        .done    (done),
        .sk_if   (sk_if)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    // Reference model: standard DES tables, subkey Ki from C0,D0 rotated by the cumulative shift.
    localparam int M_PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int M_PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int M_SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    logic [47:0] exp_sk  [16];
    logic [3:0]  exp_idx [16];
    logic [47:0] got_sk  [16];
    logic [3:0]  got_idx [16];
    logic [47:0] saved_sk[16];

    function automatic logic [27:0] rol(input logic [27:0] x, input int n);
        logic [55:0] dbl;
        dbl = {x, x} << n;
        return dbl[55:28];
    endfunction

    task automatic model_run(input logic [63:0] key, input logic dec);
        logic [55:0] cd;
        logic [55:0] cdk;
        logic [63:0] kt;
        logic [55:0] ct;
        logic [47:0] sk;
        logic [47:0] kround [17];
        int          cum;
        cd = '0;
        for (int i = 0; i < 56; i++) begin
            kt = key >> (64 - M_PC1[i]);
            cd = {cd[54:0], kt[0]};
        end
        cum = 0;
        kround[0] = '0;
        for (int k = 1; k <= 16; k++) begin
            cum += M_SHIFTS[k-1];
            cdk = {rol(cd[55:28], cum % 28), rol(cd[27:0], cum % 28)};
            sk  = '0;
            for (int j = 0; j < 48; j++) begin
                ct = cdk >> (56 - M_PC2[j]);
                sk = {sk[46:0], ct[0]};
            end
            kround[k] = sk;
        end
        for (int p = 0; p < 16; p++) begin
            exp_sk[p]  = dec ? kround[16-p] : kround[p+1];
            exp_idx[p] = dec ? 4'(15 - p) : 4'(p);
        end
    endtask

    // Runs one stream starting at the current negedge; ends at the negedge of the done cycle
    // (or right after a mid-run reset when rst_at >= 0).
    task automatic run_stream(input logic [63:0] key, input logic dec, input bit rnd,
                              input int inject_at, input int rst_at);
        int          n;
        int          cycles;
        bit          stalled;
        logic [47:0] hold_sk;
        logic [3:0]  hold_idx;
        n       = 0;
        cycles  = 0;
        stalled = 1'b0;
        hold_sk = '0;
        hold_idx = '0;
        model_run(key, dec);
        start   = 1'b1;
        key_in  = key;
        decrypt = dec;
        sk_if.sk_ready = 1'b0;
        @(negedge clk);
        start   = 1'b0;
        key_in  = {$urandom, $urandom};
        decrypt = ~dec;
        check("valid_after_start", 64'(sk_if.sk_valid), 64'd1);
        check("done_low_in_run", 64'(done), 64'd0);
        while (n < 16) begin
            if (cycles > 400) begin
                check("stream_timeout", 64'(n), 64'd16);
                return;
            end
            if (rst_at == n) begin
                rst   = 1'b1;
                start = 1'b0;
                sk_if.sk_ready = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("rst_mid_valid", 64'(sk_if.sk_valid), 64'd0);
                check("rst_mid_busy", 64'(busy), 64'd0);
                check("rst_mid_sk_out", 64'(sk_if.sk_out), 64'd0);
                check("rst_mid_sk_index", 64'(sk_if.sk_index), 64'd0);
                check("rst_mid_done", 64'(done), 64'd0);
                return;
            end
            if (n == inject_at) begin
                start   = 1'b1;
                key_in  = ~key;
                decrypt = ~dec;
            end else begin
                start = 1'b0;
            end
            sk_if.sk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            check("busy_in_run", 64'(busy), 64'd1);
            check("valid_in_run", 64'(sk_if.sk_valid), 64'd1);
            if (stalled) begin
                check("stall_hold_sk", 64'(sk_if.sk_out), 64'(hold_sk));
                check("stall_hold_idx", 64'(sk_if.sk_index), 64'(hold_idx));
            end
            if (sk_if.sk_ready) begin
                check($sformatf("sk_out[%0d]", n), 64'(sk_if.sk_out), 64'(exp_sk[n]));
                check($sformatf("sk_index[%0d]", n), 64'(sk_if.sk_index), 64'(exp_idx[n]));
                got_sk[n]  = sk_if.sk_out;
                got_idx[n] = sk_if.sk_index;
                n++;
                stalled = 1'b0;
            end else begin
                stalled  = 1'b1;
                hold_sk  = sk_if.sk_out;
                hold_idx = sk_if.sk_index;
            end
            cycles++;
            @(negedge clk);
        end
        start = 1'b0;
        sk_if.sk_ready = 1'b0;
        if (!rnd) check("cycles_for_16", 64'(cycles), 64'd16);
        check("done_pulse", 64'(done), 64'd1);
        check("valid_after_last", 64'(sk_if.sk_valid), 64'd0);
        check("busy_after_last", 64'(busy), 64'd0);
    endtask

    typedef struct {
        logic [63:0] key;
        logic        dec;
        int          pos;
        logic [47:0] sk;
        logic [3:0]  idx;
    } vec_t;

    vec_t vecs [5];

    localparam logic [63:0] STD_KEY = 64'h133457799BBCDFF1;
    localparam logic [63:0] BP_KEY  = 64'h74ABBDA83B018E2B;
    localparam logic [63:0] B2B_KEY = 64'h6A4752E3AC25FCB5;

    initial begin
        vecs[0] = '{key: STD_KEY, dec: 1'b0, pos: 0,  sk: 48'h1B02EFFC7072, idx: 4'd0};
        vecs[1] = '{key: STD_KEY, dec: 1'b0, pos: 1,  sk: 48'h79AED9DBC9E5, idx: 4'd1};
        vecs[2] = '{key: STD_KEY, dec: 1'b0, pos: 15, sk: 48'hCB3D8B0E17F5, idx: 4'd15};
        vecs[3] = '{key: STD_KEY, dec: 1'b1, pos: 0,  sk: 48'hCB3D8B0E17F5, idx: 4'd15};
        vecs[4] = '{key: STD_KEY, dec: 1'b1, pos: 15, sk: 48'h1B02EFFC7072, idx: 4'd0};

        rst     = 1'b1;
        start   = 1'b0;
        key_in  = '0;
        decrypt = 1'b0;
        sk_if.sk_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_valid", 64'(sk_if.sk_valid), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_sk_out", 64'(sk_if.sk_out), 64'd0);
        check("reset_sk_index", 64'(sk_if.sk_index), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Standard-vector table; consecutive runs also start in each done cycle.
        for (int v = 0; v < 5; v++) begin
            run_stream(vecs[v].key, vecs[v].dec, 1'b0, -1, -1);
            check($sformatf("vec%0d_sk", v), 64'(got_sk[vecs[v].pos]), 64'(vecs[v].sk));
            check($sformatf("vec%0d_idx", v), 64'(got_idx[vecs[v].pos]), 64'(vecs[v].idx));
        end

        // Decrypt stream is the encrypt stream reversed.
        run_stream(STD_KEY, 1'b0, 1'b0, -1, -1);
        for (int p = 0; p < 16; p++) saved_sk[p] = got_sk[p];
        run_stream(STD_KEY, 1'b1, 1'b0, -1, -1);
        for (int p = 0; p < 16; p++)
            check($sformatf("dec_reversed[%0d]", p), 64'(got_sk[p]), 64'(saved_sk[15-p]));

        // Backpressure in both directions, compared to the full-rate run.
        for (int d = 0; d < 2; d++) begin
            run_stream(BP_KEY, 1'(d), 1'b0, -1, -1);
            for (int p = 0; p < 16; p++) saved_sk[p] = got_sk[p];
            run_stream(BP_KEY, 1'(d), 1'b1, -1, -1);
            for (int p = 0; p < 16; p++)
                check($sformatf("bp_dir%0d[%0d]", d, p), 64'(got_sk[p]), 64'(saved_sk[p]));
        end

        // Start with a new key while busy at round 5 is ignored.
        run_stream(STD_KEY, 1'b0, 1'b0, 5, -1);

        // Back-to-back: start in the done cycle with a fresh key.
        run_stream(B2B_KEY, 1'b0, 1'b0, -1, -1);

        // Reset at round 7, then a clean start yields K1.
        run_stream(BP_KEY, 1'b0, 1'b0, -1, 7);
        @(negedge clk);
        run_stream(STD_KEY, 1'b0, 1'b0, -1, -1);
        check("k1_after_reset", 64'(got_sk[0]), 64'h1B02EFFC7072);

        // Random keys, directions and backpressure.
        for (int t = 0; t < 6; t++)
            run_stream({$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b1, -1, -1);

        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/key_schedule_iter.md
# key_schedule_iter

Sequential DES key schedule that turns one 64-bit key into the 16 round subkeys, one 48-bit subkey per accepted handshake. The `decrypt` input selects the direction:
- **Encrypt:** K1..K16, using left rotations.
- **Decrypt:** K16..K1, using right rotations.

The block sits between the key register and the round datapath. It feeds the round engine through a valid/ready stream, so the round engine can stall it.

## Interface
Parameters: none.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: load `key_in` and `decrypt`; sampled only in IDLE.
- `key_in` in 64: DES key; bit [63] is DES bit 1; parity bits are ignored.
- `decrypt` in 1: 0 = emit K1..K16, 1 = emit K16..K1.
- `sk_out` out 48: current subkey, PC2(C,D); bit [47] is DES bit 1.
- `sk_index` out 4: round number of `sk_out`, minus 1 (0..15).
- `sk_valid` out 1: `sk_out`/`sk_index` are valid.
- `sk_ready` in 1: consumer accepts when `sk_valid && sk_ready`.
- `busy` out 1: high from the cycle after `start` until the last handshake.
- `done` out 1: one-cycle pulse in the cycle after the 16th handshake.

## Operation
- States: IDLE and RUN.
- Shift table S[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- Start, IDLE with `start`=1:
  - Latch `dir` = `decrypt`; set round counter r = 0.
  - Load {C,D} = PC1(`key_in`): C = 28 MSBs, D = 28 LSBs.
  - Encrypt: apply a left rotate by S[1] to C and D independently during the load.
  - Decrypt: no rotate (K16 uses C0,D0, since the total shift is 28).
  - Go to RUN.
- RUN:
  - `sk_valid`=1, `sk_out`=PC2(C,D).
  - `sk_index` = r (encrypt) or 15−r (decrypt).
- Handshake in RUN with r<15:
  - r ← r+1.
  - Encrypt: C,D rotate left by S[r+2].
  - Decrypt: C,D rotate right by S[16−r].
- Handshake in RUN with r=15:
  - Go to IDLE; `sk_valid` ← 0; `done` ← 1 for one cycle.
- `sk_valid` stays high while stalled (`sk_ready`=0); `sk_out`/`sk_index` hold stable.
- `start` in RUN is ignored; `key_in`/`decrypt` changes in RUN have no effect.
- `start` in the `done` cycle (state is IDLE) is accepted normally.
- Reset, or reset mid-run: state=IDLE, r=0, C=D=0, `sk_valid`=0, `busy`=0, `done`=0, `sk_index`=0.
  - `sk_out`=PC2(0)=0.
  - A pending subkey is discarded.

## Timing
- `start` at edge N → first subkey valid after edge N (cycle N+1); latency 1.
- With `sk_ready` held at 1: 16 subkeys in 16 consecutive cycles, then `done` in the cycle after.
- `sk_ready` has no combinational path to `sk_valid`; `sk_out` is combinational from the C/D registers only.

## Structure
- Shared package `des_pkg` holds:
  - the shift table S;
  - PC2 index constants;
  - the state encoding;
  - width constants (KEY_W=64, CD_W=56, SK_W=48).
- The existing `pc1` is instantiated unchanged on `key_in`.
- New combinational sub-module `pc2`: 56→48 selection.
- Rotators are local functions: 28-bit rotate by 1 or 2, left or right.

## Test plan
- **Encrypt, standard vector.** Key 0x133457799BBCDFF1, decrypt=0, `sk_ready`=1:
  - PC1 = 0xF0CCAAF556678F.
  - Subkeys K1=0x1B02EFFC7072, K2=0x79AED9DBC9E5, …, K16=0xCB3D8B0E17F5, in 16 consecutive cycles.
  - `done` one cycle later.
- **Decrypt, same key:**
  - First `sk_out`=0xCB3D8B0E17F5 with `sk_index`=15.
  - Last `sk_out`=0x1B02EFFC7072 with `sk_index`=0.
  - Full sequence equals the encrypt sequence reversed.
- **Backpressure:**
  - Random `sk_ready` (about 50%) on key 0x74ABBDA83B018E2B, both directions.
  - Subkeys match the `sk_ready`=1 run; values stay stable while stalled.
  - Exactly 16 handshakes.
- **Start while busy:**
  - Pulse `start` with a new key at round 5.
  - The stream continues with the original key; the new key is taken only from IDLE.
- **Reset mid-run:**
  - Assert `rst` at round 7.
  - Next cycle: `sk_valid`=0, `busy`=0, `sk_out`=0, `sk_index`=0.
  - A subsequent `start` yields K1 correctly.
- **Back-to-back keys:**
  - `start` in the `done` cycle with key 0x6A4752E3AC25FCB5.
  - Second stream begins the next cycle; its first subkey is PC2 of PC1 rotated left by 1.
